// File: rtl/ofdm_scrambler_if.sv
// Bit-stream interface around the OFDM scrambler.
// Carries the serial input stream (scram_din/_vld/_rdy) and the scrambled output stream
// (scram_dout/_vld/_rdy) together with its per-bit sideband: symbol index, symbol-last and
// frame-last flags.
//   slave  : scrambler view (consumes scram_din, produces scram_dout)
//   master : environment view (produces scram_din, consumes scram_dout)
interface ofdm_scrambler_if;
    logic       scram_din;
    logic       scram_din_vld;
    logic       scram_din_rdy;
    logic       scram_dout;
    logic       scram_dout_vld;
    logic       scram_dout_rdy;
    logic [7:0] scram_dout_symb_cnt;
    logic       scram_dout_symb_last;
    logic       scram_dout_frame_last;

    modport slave (
        input  scram_din, scram_din_vld, scram_dout_rdy,
        output scram_din_rdy, scram_dout, scram_dout_vld,
        output scram_dout_symb_cnt, scram_dout_symb_last, scram_dout_frame_last
    );

    modport master (
        output scram_din, scram_din_vld, scram_dout_rdy,
        input  scram_din_rdy, scram_dout, scram_dout_vld,
        input  scram_dout_symb_cnt, scram_dout_symb_last, scram_dout_frame_last
    );
endinterface

// File: rtl/ofdm_scrambler.sv
// TX-side OFDM data-field scrambler (x^7 + x^4 + 1 additive LFSR).
// Scrambles the serial SERVICE+PSDU stream, appends 6 zero tail bits and scrambled pad bits
// up to a whole symbol, and tags every output bit with symbol index and last flags.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : frame start pulse (ignored while busy)
//   psdu_len  : PSDU length in bytes, sampled on start
//   seed      : LFSR seed, sampled on start; 0 selects DEFAULT_SEED
//   scram_bypass : (only with OFDM_SCRAMBLER_BYPASS_EN) pass data unscrambled, sampled on start
//   busy      : frame in progress or last bit not yet accepted
//   strm      : input/output bit streams (ofdm_scrambler_if, slave side)
// Optional feature macro: OFDM_SCRAMBLER_BYPASS_EN.
module ofdm_scrambler #(
    parameter int unsigned N_DBPS          = 96,
    parameter int unsigned FIRST_DATA_SYMB = 4,
    parameter logic [6:0]  DEFAULT_SEED    = 7'b1011101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [11:0]       psdu_len,
    input  logic [6:0]        seed,
`ifdef OFDM_SCRAMBLER_BYPASS_EN
    input  logic              scram_bypass,
`endif
    output logic              busy,
    ofdm_scrambler_if.slave   strm
);

    localparam int unsigned   SBW     = (N_DBPS > 1) ? $clog2(N_DBPS) : 1;
    localparam logic [SBW-1:0] LastBit = SBW'(N_DBPS - 1);

    typedef enum logic [1:0] {StIdle, StData, StTail, StPad} state_t;

    state_t         state_q, state_d;
    logic [6:0]     lfsr_q;
    logic [15:0]    data_left_q;
    logic [2:0]     tail_cnt_q;
    logic [SBW-1:0] symb_bit_q;
    logic [7:0]     symb_cnt_q;
    logic           bypass;

    logic           dout_q, dout_vld_q, symb_last_q, frame_last_q;
    logic [7:0]     dout_symb_cnt_q;

    logic           can_emit, fb, symb_wrap;
    logic           gen, gen_bit, gen_last, start_acc;

`ifdef OFDM_SCRAMBLER_BYPASS_EN
    logic bypass_q;
    assign bypass = bypass_q;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        can_emit  = !dout_vld_q || strm.scram_dout_rdy;
        fb        = lfsr_q[6] ^ lfsr_q[3];
        symb_wrap = (symb_bit_q == LastBit);
        state_d   = state_q;
        gen       = 1'b0;
        gen_bit   = 1'b0;
        gen_last  = 1'b0;
        start_acc = 1'b0;
        unique case (state_q)
            StIdle: begin
                // In IDLE busy is only held up by a not-yet-accepted final bit.
                start_acc = start && !dout_vld_q;
                if (start_acc) state_d = StData;
            end
            StData: begin
                if (strm.scram_din_vld && can_emit) begin
                    gen     = 1'b1;
                    gen_bit = bypass ? strm.scram_din : (strm.scram_din ^ fb);
                    if (data_left_q == 16'd1) state_d = StTail;
                end
            end
            StTail: begin
                if (can_emit) begin
                    gen = 1'b1;
                    if (tail_cnt_q == 3'd5) begin
                        if (symb_wrap) begin
                            gen_last = 1'b1;
                            state_d  = StIdle;
                        end else begin
                            state_d = StPad;
                        end
                    end
                end
            end
            StPad: begin
                if (can_emit) begin
                    gen     = 1'b1;
                    gen_bit = bypass ? 1'b0 : fb;
                    if (symb_wrap) begin
                        gen_last = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The FSM drops to IDLE once the final bit is generated; busy stays high through
    // scram_dout_vld until that bit is accepted, so a start is not taken before then.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            lfsr_q          <= DEFAULT_SEED;
            data_left_q     <= '0;
            tail_cnt_q      <= '0;
            symb_bit_q      <= '0;
            symb_cnt_q      <= '0;
            dout_q          <= 1'b0;
            dout_vld_q      <= 1'b0;
            dout_symb_cnt_q <= '0;
            symb_last_q     <= 1'b0;
            frame_last_q    <= 1'b0;
`ifdef OFDM_SCRAMBLER_BYPASS_EN
            bypass_q        <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                lfsr_q      <= (seed == 7'd0) ? DEFAULT_SEED : seed;
                data_left_q <= 16'd16 + {1'b0, psdu_len, 3'b000};
                tail_cnt_q  <= '0;
                symb_bit_q  <= '0;
                symb_cnt_q  <= 8'(FIRST_DATA_SYMB);
`ifdef OFDM_SCRAMBLER_BYPASS_EN
                bypass_q    <= scram_bypass;
`endif
            end
            if (gen) begin
                lfsr_q <= {lfsr_q[5:0], fb};
                if (state_q == StData) data_left_q <= data_left_q - 16'd1;
                if (state_q == StTail) tail_cnt_q <= tail_cnt_q + 3'd1;
                symb_bit_q      <= symb_wrap ? '0 : symb_bit_q + 1'b1;
                if (symb_wrap) symb_cnt_q <= symb_cnt_q + 8'd1;
                dout_q          <= gen_bit;
                dout_vld_q      <= 1'b1;
                dout_symb_cnt_q <= symb_cnt_q;
                symb_last_q     <= symb_wrap;
                frame_last_q    <= gen_last;
            end else if (strm.scram_dout_rdy) begin
                dout_vld_q <= 1'b0;
            end
        end
    end

    assign strm.scram_din_rdy         = (state_q == StData) && can_emit;
    assign strm.scram_dout            = dout_q;
    assign strm.scram_dout_vld        = dout_vld_q;
    assign strm.scram_dout_symb_cnt   = dout_symb_cnt_q;
    assign strm.scram_dout_symb_last  = symb_last_q;
    assign strm.scram_dout_frame_last = frame_last_q;
    assign busy                       = (state_q != StIdle) || dout_vld_q;

endmodule

// File: tb/tb_ofdm_scrambler.sv
// Self-checking bench for ofdm_scrambler: directed frames with a scoreboard of expected
// output bits, known-sequence, loopback, backpressure and mid-frame reset checks.
module tb_ofdm_scrambler;
    localparam int NDBPS = 96;

    logic        clk = 1'b0;
    logic        rst, start, busy;
    logic [11:0] psdu_len;
    logic [6:0]  seed;
`ifdef OFDM_SCRAMBLER_BYPASS_EN
    logic        scram_bypass;
`endif

    always #5 clk = ~clk;

    ofdm_scrambler_if sif ();

    ofdm_scrambler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .psdu_len     (psdu_len),
        .seed         (seed),
`ifdef OFDM_SCRAMBLER_BYPASS_EN
        .scram_bypass (scram_bypass),
`endif
        .busy         (busy),
        .strm         (sif)
    );

    int          total = 0;
    int          bad = 0;
    logic        in_bits[$];
    logic        got_q[$];
    logic        ref_q[$];
    logic [10:0] exp_q[$];  // {bit, symb_cnt, symb_last, frame_last}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int len, input bit zero);
        in_bits.delete();
        for (int i = 0; i < 16 + 8 * len; i++) in_bits.push_back(zero ? 1'b0 : 1'($urandom % 2));
    endtask

    function automatic int frame_bits(input int len);
        return ((16 + 8 * len + 6 + NDBPS - 1) / NDBPS) * NDBPS;
    endfunction

    // Reference model: LFSR x^7+x^4+1, tail forced to 0, pad = scrambled zeros.
    function automatic void build_exp(input int len, input logic [6:0] sd);
        logic [6:0] s = (sd == 7'd0) ? 7'b1011101 : sd;
        int   nd = 16 + 8 * len;
        int   nt = nd + 6;
        int   nout = frame_bits(len);
        logic f, b;
        exp_q.delete();
        for (int i = 0; i < nout; i++) begin
            f = s[6] ^ s[3];
            if (i < nd)      b = in_bits[i] ^ f;
            else if (i < nt) b = 1'b0;
            else             b = f;
            s = {s[5:0], f};
            exp_q.push_back({b, 8'(4 + i / NDBPS), (i % NDBPS) == NDBPS - 1, i == nout - 1});
        end
    endfunction

    task automatic run_frame(input int len, input logic [6:0] sd, input int stall, input int gap,
                             input int abort_at, input bit start_on_last);
        int          idx = 0;
        int          n_out = 0;
        int          nd = in_bits.size();
        bit          done = 0;
        bit          prev_stall = 0;
        logic [11:0] cur, prev_out;
        logic [10:0] e;
        got_q.delete();
        @(negedge clk);
        start = 1'b1; psdu_len = 12'(len); seed = sd;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            sif.scram_din      = (idx < nd) ? in_bits[idx] : 1'b1;
            sif.scram_din_vld  = (int'($urandom_range(99)) >= gap);
            sif.scram_dout_rdy = (int'($urandom_range(99)) >= stall);
            #1;
            cur = {sif.scram_dout, sif.scram_dout_vld, sif.scram_dout_symb_cnt,
                   sif.scram_dout_symb_last, sif.scram_dout_frame_last};
            if (prev_stall) check("stall_hold", 32'(cur), 32'(prev_out));
            if (sif.scram_dout_vld && !sif.scram_dout_rdy)
                check("din_rdy_stall", 32'(sif.scram_din_rdy), 32'd0);
            if (sif.scram_din_vld && sif.scram_din_rdy) begin
                check("overconsume", 32'(idx), 32'(idx < nd ? idx : nd - 1));
                idx++;
            end
            if (sif.scram_dout_vld && sif.scram_dout_rdy) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $error("FAIL extra_out observed=bit%0d expected=none", n_out);
                    done = 1;
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("out_bit%0d", n_out), 32'(cur[11:0] & 12'hBFF),
                          32'({e[10], 1'b0, e[9:0]}));
                    got_q.push_back(sif.scram_dout);
                    n_out++;
                    if (e[0]) begin
                        done = 1;
                        if (start_on_last) begin
                            start = 1'b1; seed = 7'h11; psdu_len = 12'd3;
                        end
                    end
                    if (abort_at > 0 && n_out == abort_at) done = 1;
                end
            end
            prev_stall = sif.scram_dout_vld && !sif.scram_dout_rdy;
            prev_out   = cur;
            @(negedge clk);
        end
        start = 1'b0;
        sif.scram_din_vld  = 1'b0;
        sif.scram_dout_rdy = 1'b1;
        if (!done) begin
            total++; bad++;
            $error("FAIL timeout observed=%0d expected=%0d", n_out, frame_bits(len));
        end
        if (abort_at == 0) begin
            check("frame_len", 32'(n_out), 32'(frame_bits(len)));
            #1;
            check("busy_after_frame", 32'(busy), 32'd0);
            if (start_on_last) begin
                @(negedge clk); #1;
                check("start_on_last_ignored", 32'({busy, sif.scram_din_rdy}), 32'd0);
            end
        end
    endtask

    task automatic check_known(input string tag);
        logic [7:0] known = 8'b01101100;
        logic [7:0] got = '0;
        for (int i = 0; i < 8 && i < got_q.size(); i++) got[7-i] = got_q[i];
        check(tag, 32'(got), 32'(known));
    endtask

    initial begin
        int         mism;
        logic [6:0] s;
        logic       f, r;
        rst = 1'b1; start = 1'b0; psdu_len = '0; seed = '0;
`ifdef OFDM_SCRAMBLER_BYPASS_EN
        scram_bypass = 1'b0;
`endif
        sif.scram_din = 1'b0; sif.scram_din_vld = 1'b0; sif.scram_dout_rdy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs", 32'({busy, sif.scram_din_rdy, sif.scram_dout, sif.scram_dout_vld,
                                 sif.scram_dout_symb_cnt, sif.scram_dout_symb_last,
                                 sif.scram_dout_frame_last}), 32'd0);
        rst = 1'b0;

        // Known sequence from the default seed.
        fill(0, 1); build_exp(0, 7'b1011101);
        run_frame(0, 7'b1011101, 0, 0, 0, 0);
        check_known("known_seq");

        // One symbol with padding; start on the last-bit cycle must be ignored.
        fill(1, 0); build_exp(1, 7'h33);
        run_frame(1, 7'h33, 0, 0, 0, 1);

        // Two symbols.
        fill(10, 0); build_exp(10, 7'h25);
        run_frame(10, 7'h25, 0, 0, 0, 0);

        // Loopback through an independent descrambler.
        fill(5, 0); build_exp(5, 7'h5A);
        run_frame(5, 7'h5A, 0, 30, 0, 0);
        s = 7'h5A; mism = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            f = s[6] ^ s[3];
            r = got_q[i] ^ f;
            if (i < in_bits.size()) begin
                if (r !== in_bits[i]) mism++;
            end else if (i < in_bits.size() + 6) begin
                if (got_q[i] !== 1'b0) mism++;
            end else if (r !== 1'b0) begin
                mism++;
            end
            s = {s[5:0], f};
        end
        check("loopback_mism", 32'(mism), 32'd0);
        ref_q = got_q;

        // Same frame under random backpressure and input gaps.
        build_exp(5, 7'h5A);
        run_frame(5, 7'h5A, 40, 10, 0, 0);
        mism = (got_q.size() == ref_q.size()) ? 0 : 1;
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            if (got_q[i] !== ref_q[i]) mism++;
        check("stall_vs_nostall", 32'(mism), 32'd0);

        // Reset in the middle of a frame.
        fill(10, 0); build_exp(10, 7'h4C);
        run_frame(10, 7'h4C, 0, 0, 50, 0);
        rst = 1'b1;
        @(negedge clk); #1;
        check("midframe_reset", 32'({busy, sif.scram_din_rdy, sif.scram_dout, sif.scram_dout_vld,
                                     sif.scram_dout_symb_cnt, sif.scram_dout_symb_last,
                                     sif.scram_dout_frame_last}), 32'd0);
        rst = 1'b0;

        // seed=0 falls back to the default seed.
        fill(0, 1); build_exp(0, 7'd0);
        run_frame(0, 7'd0, 0, 0, 0, 0);
        check_known("known_seq_seed0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
